// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit driving the Datapath
// control lines for ld, ldi, st, add, sub, and, or, addi, andi, ori, nop, halt.
//   clk, clr      : clock, asynchronous active-high reset to RESET
//   ir            : instruction from the datapath IR, opcode in ir[31:27]
//   stop          : halt request sampled only in an instruction's last state
//   run           : low in RESET and HALT
//   illegal       : sticky unsupported-opcode flag (only with CU_ILLEGAL_TRAP_EN)
//   *_out, BAout  : bus drivers; *_rd, Rin : register loads
//   IncPC/Read/Write, Gra/Grb/Grc, op_sel : PC/memory, field selects, ALU op
// Optional feature macro: CU_ILLEGAL_TRAP_EN (trap unsupported opcodes to HALT).
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic        run,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic        PC_out,
    output logic        Zlo_out,
    output logic        MDR_out,
    output logic        R_out,
    output logic        C_out,
    output logic        BAout,
    output logic        MAR_rd,
    output logic        Zlo_rd,
    output logic        PC_rd,
    output logic        MDR_rd,
    output logic        IR_rd,
    output logic        Y_rd,
    output logic        Rin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  op_sel
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op;
    logic       is_ld, is_ldi, is_st, is_alu, is_imm, is_nop, is_halt;
    logic       ld_st, base, exec, trap, last;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign is_ld     = op == 5'b00000;
    assign is_ldi    = op == 5'b00001;
    assign is_st     = op == 5'b00010;
    assign is_alu    = op >= 5'b00011 && op <= 5'b00110;
    assign is_imm    = op >= 5'b01100 && op <= 5'b01110;
    assign is_nop    = op == 5'b11010;
    assign is_halt   = op == 5'b11011;
    assign ld_st     = is_ld | is_st;
    // ld, ldi and st all form a base+displacement address in T3/T4
    assign base      = ld_st | is_ldi;
    assign exec      = base | is_alu | is_imm;
`ifdef CU_ILLEGAL_TRAP_EN
    assign trap      = !(exec | is_nop | is_halt);
`else
    assign trap      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last    = 1'b0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = (is_halt || trap) ? S_HALT : exec ? S_T3 : S_T0;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    if (ld_st) state_d = S_T6; else last = 1'b1;
            S_T6:    state_d = S_T7;
            S_T7:    last = 1'b1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
        // stop is only honoured at an instruction boundary
        if (last) state_d = stop ? S_HALT : S_T0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_RESET;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef CU_ILLEGAL_TRAP_EN
            if (state_q == S_T2 && trap) illegal <= 1'b1;
`endif
        end
    end

    assign run = state_q != S_RESET && state_q != S_HALT;

    always_comb begin
        PC_out  = 1'b0;
        Zlo_out = 1'b0;
        MDR_out = 1'b0;
        R_out   = 1'b0;
        C_out   = 1'b0;
        BAout   = 1'b0;
        MAR_rd  = 1'b0;
        Zlo_rd  = 1'b0;
        PC_rd   = 1'b0;
        MDR_rd  = 1'b0;
        IR_rd   = 1'b0;
        Y_rd    = 1'b0;
        Rin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        op_sel  = 5'b00000;
        case (state_q)
            S_T0: begin
                PC_out = 1'b1;
                MAR_rd = 1'b1;
                IncPC  = 1'b1;
                Zlo_rd = 1'b1;
            end
            S_T1: begin
                Zlo_out = 1'b1;
                PC_rd   = 1'b1;
                Read    = 1'b1;
                MDR_rd  = 1'b1;
            end
            S_T2: begin
                MDR_out = 1'b1;
                IR_rd   = 1'b1;
            end
            S_T3: begin
                Grb   = exec;
                R_out = exec;
                Y_rd  = exec;
                BAout = base;
            end
            S_T4: begin
                C_out  = base | is_imm;
                Grc    = is_alu;
                R_out  = is_alu;
                Zlo_rd = exec;
                // immediates reuse the matching register-form ALU code
                op_sel = base ? 5'b00011 : is_alu ? op :
                         !is_imm ? 5'b00000 : op == 5'b01100 ? 5'b00011 :
                         op == 5'b01101 ? 5'b00101 : 5'b00110;
            end
            S_T5: begin
                Zlo_out = exec;
                MAR_rd  = ld_st;
                Gra     = exec & !ld_st;
                Rin     = exec & !ld_st;
            end
            S_T6: begin
                Read   = is_ld;
                MDR_rd = ld_st;
                Gra    = is_st;
                R_out  = is_st;
            end
            S_T7: begin
                MDR_out = is_ld;
                Gra     = is_ld;
                Rin     = is_ld;
                Write   = is_st;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of the control_sequencer state/output sequence.
module tb_control_sequencer;

    logic        clk, clr, stop;
    logic [31:0] ir;
    logic        run, PC_out, Zlo_out, MDR_out, R_out, C_out, BAout;
    logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Rin;
    logic        IncPC, Read, Write, Gra, Grb, Grc;
    logic [4:0]  op_sel;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [19:0] ctl;
    int          checks = 0;
    int          errors = 0;

    localparam logic [19:0] PCO = 20'h80000, ZO = 20'h40000, MDRO = 20'h20000, RO = 20'h10000;
    localparam logic [19:0] CO = 20'h08000, BA = 20'h04000, MAR = 20'h02000, ZIN = 20'h01000;
    localparam logic [19:0] PCIN = 20'h00800, MDRIN = 20'h00400, IRIN = 20'h00200, YIN = 20'h00100;
    localparam logic [19:0] RIN = 20'h00080, INC = 20'h00040, RD = 20'h00020, WR = 20'h00010;
    localparam logic [19:0] GA = 20'h00008, GB = 20'h00004, GC = 20'h00002, RUN = 20'h00001;
    localparam logic [19:0] F0 = PCO | MAR | INC | ZIN | RUN;
    localparam logic [19:0] F1 = ZO | PCIN | RD | MDRIN | RUN;
    localparam logic [19:0] F2 = MDRO | IRIN | RUN;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop), .run(run),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .PC_out(PC_out), .Zlo_out(Zlo_out), .MDR_out(MDR_out), .R_out(R_out),
        .C_out(C_out), .BAout(BAout), .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd),
        .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .Rin(Rin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .op_sel(op_sel)
    );

    assign ctl = {PC_out, Zlo_out, MDR_out, R_out, C_out, BAout, MAR_rd, Zlo_rd, PC_rd,
                  MDR_rd, IR_rd, Y_rd, Rin, IncPC, Read, Write, Gra, Grb, Grc, run};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic recover();
        #2 clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (ctl !== 20'h0 || op_sel !== 5'd0) begin
            errors++;
            $display("FAIL reset_hold: ctl=%h op_sel=%b expected ctl=00000 op_sel=00000", ctl, op_sel);
        end
        clr = 1'b0;
        #1 checks++;
        if (ctl !== 20'h0) begin
            errors++;
            $display("FAIL reset_cycle: ctl=%h expected 00000", ctl);
        end
        @(negedge clk);
        checks++;
        if (ctl !== F0) begin
            errors++;
            $display("FAIL first_t0: ctl=%h expected %h", ctl, F0);
        end
        ir = 32'h00900054;
        repeat (4) @(negedge clk);
        checks++;
        if (ctl !== (CO | ZIN | RUN) || op_sel !== 5'b00011) begin
            errors++;
            $display("FAIL ld_t4_before_clr: ctl=%h op_sel=%b expected ctl=%h op_sel=00011", ctl, op_sel, CO | ZIN | RUN);
        end
        #2 clr = 1'b1;
        #1 checks++;
        if (ctl !== 20'h0 || op_sel !== 5'd0) begin
            errors++;
            $display("FAIL async_clr: ctl=%h op_sel=%b expected ctl=00000 op_sel=00000", ctl, op_sel);
        end
        @(negedge clk) clr = 1'b0;
        #1 checks++;
        if (ctl !== 20'h0) begin
            errors++;
            $display("FAIL reset_after_clr: ctl=%h expected 00000", ctl);
        end
        @(negedge clk);
        checks++;
        if (ctl !== F0) begin
            errors++;
            $display("FAIL t0_after_clr: ctl=%h expected %h", ctl, F0);
        end
    endtask

    task automatic test_ld();
        logic [19:0] e [9];
        logic [4:0]  o [9];
        ir = 32'h00900054;
        e = '{F0, F1, F2, GB | BA | RO | YIN | RUN, CO | ZIN | RUN, ZO | MAR | RUN,
              RD | MDRIN | RUN, MDRO | GA | RIN | RUN, F0};
        o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ctl !== e[i] || op_sel !== o[i]) begin
                errors++;
                $display("FAIL ld cycle %0d: ctl=%h op_sel=%b expected ctl=%h op_sel=%b", i, ctl, op_sel, e[i], o[i]);
            end
            if (i < 8) @(negedge clk);
        end
    endtask

    task automatic test_st();
        logic [19:0] e [9];
        logic [4:0]  o [9];
        ir = 32'h11800034;
        e = '{F0, F1, F2, GB | BA | RO | YIN | RUN, CO | ZIN | RUN, ZO | MAR | RUN,
              GA | RO | MDRIN | RUN, WR | RUN, F0};
        o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ctl !== e[i] || op_sel !== o[i]) begin
                errors++;
                $display("FAIL st cycle %0d: ctl=%h op_sel=%b expected ctl=%h op_sel=%b", i, ctl, op_sel, e[i], o[i]);
            end
            if (i < 8) @(negedge clk);
        end
    endtask

    task automatic test_alu_imm();
        logic [31:0] irs [6];
        logic [4:0]  ops [6];
        logic        imm [6];
        logic [19:0] e [7];
        irs  = '{32'h1A920000, 32'h20000000, 32'h28000000, 32'h30000000, 32'h68000000, 32'h70000000};
        ops  = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd5, 5'd6};
        imm  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            ir = irs[k];
            e = '{F0, F1, F2, GB | RO | YIN | RUN,
                  imm[k] ? (CO | ZIN | RUN) : (GC | RO | ZIN | RUN), ZO | GA | RIN | RUN, F0};
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (ctl !== e[i] || op_sel !== (i == 4 ? ops[k] : 5'd0)) begin
                    errors++;
                    $display("FAIL alu ir=%h cycle %0d: ctl=%h op_sel=%b expected ctl=%h op_sel=%b", irs[k], i, ctl, op_sel, e[i], i == 4 ? ops[k] : 5'd0);
                end
                if (i < 6) @(negedge clk);
            end
        end
    endtask

    task automatic test_nop_illegal();
        logic [19:0] e [4];
        ir = 32'hD0000000;
        e = '{F0, F1, F2, F0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== e[i]) begin
                errors++;
                $display("FAIL nop cycle %0d: ctl=%h expected %h", i, ctl, e[i]);
            end
            if (i < 3) @(negedge clk);
        end
        ir = 32'hF8000000;
        repeat (3) @(negedge clk);
`ifdef CU_ILLEGAL_TRAP_EN
        checks++;
        if (ctl !== 20'h0 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_trap: ctl=%h illegal=%b expected ctl=00000 illegal=1", ctl, illegal);
        end
        recover();
        checks++;
        if (ctl !== F0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: ctl=%h illegal=%b expected ctl=%h illegal=0", ctl, illegal, F0);
        end
`else
        checks++;
        if (ctl !== F0) begin
            errors++;
            $display("FAIL illegal_as_nop: ctl=%h expected %h", ctl, F0);
        end
        @(negedge clk);
        checks++;
        if (ctl !== F1) begin
            errors++;
            $display("FAIL illegal_continue: ctl=%h expected %h", ctl, F1);
        end
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_stop();
        logic [19:0] e [6];
        ir = 32'h60000000;
        stop = 1'b1;
        e = '{F0, F1, F2, GB | RO | YIN | RUN, CO | ZIN | RUN, ZO | GA | RIN | RUN};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ctl !== e[i] || op_sel !== (i == 4 ? 5'd3 : 5'd0)) begin
                errors++;
                $display("FAIL addi_stop cycle %0d: ctl=%h op_sel=%b expected ctl=%h", i, ctl, op_sel, e[i]);
            end
            @(negedge clk);
        end
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== 20'h0) begin
                errors++;
                $display("FAIL stop_halt cycle %0d: ctl=%h expected 00000", i, ctl);
            end
            @(negedge clk);
        end
        recover();
    endtask

    task automatic test_halt();
        logic [19:0] e [3];
        ir = 32'hD8000000;
        e = '{F0, F1, F2};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== e[i]) begin
                errors++;
                $display("FAIL halt_fetch cycle %0d: ctl=%h expected %h", i, ctl, e[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (ctl !== 20'h0 || op_sel !== 5'd0) begin
                errors++;
                $display("FAIL halted cycle %0d: ctl=%h op_sel=%b expected ctl=00000 op_sel=00000", i, ctl, op_sel);
            end
            @(negedge clk);
        end
        recover();
        checks++;
        if (ctl !== F0) begin
            errors++;
            $display("FAIL halt_recover: ctl=%h expected %h", ctl, F0);
        end
    endtask

    initial begin
        clr = 1'b1;
        stop = 1'b0;
        ir = 32'h0;
        test_reset();
        test_ld();
        test_st();
        test_alu_imm();
        test_nop_illegal();
        test_stop();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
